// File: rtl/booth_decode_acc64.sv
// booth_decode_acc64: sequential radix-4 Booth decoder/accumulator.
// Latches a multiplicand and the per-digit zero/invert/double vectors.
// Decodes DIGITS_PER_CYCLE digits per clock into partial products (0, +-M, +-2M).
// Each partial product is shifted by 2*digit and added into a 2*REG_WIDTH accumulator.
// The product is returned through a valid/ready handshake.
//
// Ports:
//   clk_i, rst_n_i             clock, async active-low reset
//   valid_i / ready_o          request handshake
//   mcand_i, mcand_signed_i    multiplicand and its extension mode
//   zero/invert/double_index_i per-digit Booth controls (REG_WIDTH/2 bits each)
//   flush_i                    synchronous abort, highest priority
//   valid_o / ready_i          response handshake
//   product_o                  2*REG_WIDTH-bit product, held after hand-off
module booth_decode_acc64 #(
   parameter int unsigned REG_WIDTH        = 64,
   parameter int unsigned DIGITS_PER_CYCLE = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [REG_WIDTH-1:0]     mcand_i,
   input  logic                     mcand_signed_i,
   input  logic [REG_WIDTH/2-1:0]   zero_index_i,
   input  logic [REG_WIDTH/2-1:0]   invert_index_i,
   input  logic [REG_WIDTH/2-1:0]   double_index_i,
   input  logic                     flush_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [2*REG_WIDTH-1:0]   product_o
);

   localparam int unsigned ND = REG_WIDTH / 2;
   localparam int unsigned PW = 2 * REG_WIDTH;
   localparam int unsigned IW = $clog2(ND);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [REG_WIDTH-1:0] mcand_q, mcand_d;
   logic                 signed_q, signed_d;
   logic [ND-1:0]        zero_q, zero_d;
   logic [ND-1:0]        inv_q, inv_d;
   logic [ND-1:0]        dbl_q, dbl_d;
   logic [PW-1:0]        acc_q, acc_d;
   logic [IW-1:0]        cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic [PW-1:0]        product_q, product_d;

   logic [PW-1:0]        mcand_ext;
   logic [PW-1:0]        step_sum;
   logic [IW-1:0]        idx;

   // Partial product of one digit, already placed at bit 2*idx.
   function automatic logic [PW-1:0] decode_digit(input logic [PW-1:0] me,
                                                  input logic          z,
                                                  input logic          inv,
                                                  input logic          dbl,
                                                  input logic [IW-1:0] pos);
      logic [PW-1:0] base;
      logic [PW-1:0] pp;
      base = dbl ? (me << 1) : me;
      pp   = inv ? (~base + 1'b1) : base;
      // Zero wins over invert/double so illegal codes still give 0.
      if (z) begin
         pp = '0;
      end
      return pp << {pos, 1'b0};
   endfunction

   assign mcand_ext = signed_q ? {{REG_WIDTH{mcand_q[REG_WIDTH-1]}}, mcand_q}
                               : {{REG_WIDTH{1'b0}}, mcand_q};

   always_comb begin
      step_sum = '0;
      idx      = '0;
      for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
         idx      = cnt_q + IW'(j);
         step_sum = step_sum + decode_digit(mcand_ext, zero_q[idx], inv_q[idx], dbl_q[idx], idx);
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      signed_d  = signed_q;
      zero_d    = zero_q;
      inv_d     = inv_q;
      dbl_d     = dbl_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      product_d = product_q;

      if (flush_i) begin
         state_d = StIdle;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_i) begin
                  mcand_d  = mcand_i;
                  signed_d = mcand_signed_i;
                  zero_d   = zero_index_i;
                  inv_d    = invert_index_i;
                  dbl_d    = double_index_i;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = StRun;
               end
            end
            StRun: begin
               acc_d = acc_q + step_sum;
               if (cnt_q == IW'(ND - DIGITS_PER_CYCLE)) begin
                  product_d = acc_q + step_sum;
                  valid_d   = 1'b1;
                  cnt_d     = '0;
                  state_d   = StDone;
               end else begin
                  cnt_d = cnt_q + IW'(DIGITS_PER_CYCLE);
               end
            end
            StDone: begin
               if (ready_i) begin
                  valid_d = 1'b0;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         signed_q  <= 1'b0;
         zero_q    <= '0;
         inv_q     <= '0;
         dbl_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         signed_q  <= signed_d;
         zero_q    <= zero_d;
         inv_q     <= inv_d;
         dbl_q     <= dbl_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         product_q <= product_d;
      end
   end

   assign ready_o   = (state_q == StIdle);
   assign valid_o   = valid_q;
   assign product_o = product_q;

endmodule

// File: tb/tb_booth_decode_acc64.sv
// Testbench for booth_decode_acc64: scoreboard of expected products and accept cycles.
// An independent monitor compares each response against the scoreboard.
module tb_booth_decode_acc64;

   localparam int LAT = 16;

   logic         clk = 1'b0;
   logic         rst_n_i;
   logic         valid_i;
   logic         ready_o;
   logic [63:0]  mcand_i;
   logic         mcand_signed_i;
   logic [31:0]  zero_index_i;
   logic [31:0]  invert_index_i;
   logic [31:0]  double_index_i;
   logic         flush_i;
   logic         valid_o;
   logic         ready_i;
   logic [127:0] product_o;

   booth_decode_acc64 dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .mcand_i        (mcand_i),
      .mcand_signed_i (mcand_signed_i),
      .zero_index_i   (zero_index_i),
      .invert_index_i (invert_index_i),
      .double_index_i (double_index_i),
      .flush_i        (flush_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .product_o      (product_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] p;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic vseen   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: value of the multiplier from its signed digits, then one multiply.
   function automatic logic [127:0] model(input logic [63:0] m, input logic s,
                                          input logic [31:0] z, input logic [31:0] inv,
                                          input logic [31:0] dbl);
      logic [127:0]        me;
      logic signed [127:0] mult;
      longint              d;
      me   = s ? {{64{m[63]}}, m} : {64'b0, m};
      mult = '0;
      for (int i = 0; i < 32; i++) begin
         d = z[i] ? 0 : (dbl[i] ? 2 : 1);
         if (inv[i]) d = -d;
         mult = mult + (128'(signed'(d)) <<< (2 * i));
      end
      return me * mult;
   endfunction

   // Monitor: compare on the first cycle each response is presented.
   always @(negedge clk) begin
      if (rst_n_i && valid_o && !vseen) begin
         vseen = 1'b1;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got product %h with nothing outstanding", product_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product", product_o, e.p);
            chk("latency", 128'(cyc - e.acc), 128'(LAT));
         end
      end
      if (!valid_o) vseen = 1'b0;
   end

   task automatic do_req(input logic [63:0] m, input logic s, input logic [31:0] z,
                         input logic [31:0] inv, input logic [31:0] dbl,
                         input logic [127:0] exp, input bit push);
      int b;
      exp_t e;
      b = 0;
      @(negedge clk);
      while (!ready_o && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (!ready_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: ready_o %b expected 1", ready_o);
      end
      mcand_i        = m;
      mcand_signed_i = s;
      zero_index_i   = z;
      invert_index_i = inv;
      double_index_i = dbl;
      valid_i        = 1'b1;
      if (push) begin
         e.p   = exp;
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      valid_i        = 1'b0;
      // Scramble inputs: only the latched copy may be used.
      mcand_i        = {$urandom, $urandom};
      mcand_signed_i = 1'($urandom);
      zero_index_i   = $urandom;
      invert_index_i = $urandom;
      double_index_i = $urandom;
   endtask

   task automatic wait_empty();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL response_timeout: %0d outstanding expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic [63:0] m;
      logic        s;
      logic [31:0] z, inv, dbl;
      int          b;

      rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
      mcand_i = '0; mcand_signed_i = 1'b0;
      zero_index_i = '0; invert_index_i = '0; double_index_i = '0;
      #1;
      chk("reset_ready", 128'(ready_o), 128'd1);
      chk("reset_valid", 128'(valid_o), 128'd0);
      chk("reset_product", product_o, 128'd0);
      repeat (2) @(negedge clk);
      rst_n_i = 1'b1;

      // Directed cases
      do_req(64'd3, 1'b0, ~32'h3, 32'h0, 32'h0, 128'd15, 1'b1);
      wait_empty();
      do_req(64'd7, 1'b0, ~32'h1, 32'h1, 32'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9, 1'b1);
      wait_empty();
      do_req(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ~32'h3, 32'h1, 32'h1,
             128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 1'b1);
      wait_empty();
      do_req(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ~32'h3, 32'h1, 32'h1, ~128'h1, 1'b1);
      wait_empty();

      // Back-pressure
      ready_i = 1'b0;
      do_req(64'd3, 1'b0, ~32'h3, 32'h0, 32'h0, 128'd15, 1'b1);
      b = 0;
      while (!valid_o && b < 100) begin
         @(negedge clk);
         b++;
      end
      chk("bp_valid_seen", 128'(valid_o), 128'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid_hold", 128'(valid_o), 128'd1);
         chk("bp_product_hold", product_o, 128'd15);
         chk("bp_ready_low", 128'(ready_o), 128'd0);
      end
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 128'(valid_o), 128'd0);
      chk("bp_release_ready", 128'(ready_o), 128'd1);
      chk("bp_product_kept", product_o, 128'd15);
      wait_empty();

      // Flush at RUN edge 7
      do_req(64'd9, 1'b0, ~32'h1, 32'h0, 32'h0, 128'd0, 1'b0);
      repeat (6) @(negedge clk);
      flush_i = 1'b1;
      valid_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("flush_ready", 128'(ready_o), 128'd1);
      chk("flush_valid", 128'(valid_o), 128'd0);
      chk("flush_product_kept", product_o, 128'd15);
      repeat (25) @(negedge clk);
      do_req(64'd3, 1'b0, ~32'h3, 32'h0, 32'h0, 128'd15, 1'b1);
      wait_empty();

      // Randomized against the reference model
      for (int t = 0; t < 40; t++) begin
         m   = {$urandom, $urandom};
         s   = 1'($urandom);
         z   = $urandom & $urandom;
         inv = $urandom;
         dbl = $urandom;
         do_req(m, s, z, inv, dbl, model(m, s, z, inv, dbl), 1'b1);
         if ($urandom_range(0, 3) == 0) wait_empty();
      end
      wait_empty();

      // Reset during RUN
      do_req(64'd5, 1'b0, 32'h0, 32'h0, 32'h0, 128'd0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n_i = 1'b0;
      #1;
      chk("rst_run_ready", 128'(ready_o), 128'd1);
      chk("rst_run_valid", 128'(valid_o), 128'd0);
      chk("rst_run_product", product_o, 128'd0);
      @(negedge clk);
      rst_n_i = 1'b1;

      // Nonzero result first so the all-zero-digit case is observable
      do_req(64'd11, 1'b1, ~32'h1, 32'h0, 32'h1, 128'd22, 1'b1);
      wait_empty();
      do_req(64'hDEAD_BEEF_0123_4567, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             128'd0, 1'b1);
      wait_empty();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_decode_acc64.md
Name: booth_decode_acc64

Overview:
- Sequential radix-4 Booth decoder/accumulator for the multiplier datapath; the consumer side of the Booth encoder.
- Takes a multiplicand plus the per-digit zero/invert/double index vectors produced for a multiplier operand.
- Decodes each digit into a partial product (0, ±M, ±2M), shifts it by 2·digit and accumulates, DIGITS_PER_CYCLE digits per clock.
- Returns the 2·REG_WIDTH-bit product through a valid/ready handshake. Used by the multi-cycle MUL path of the ALU.

Parameters:
- REG_WIDTH, 64: operand width; digit count ND = REG_WIDTH/2.
- DIGITS_PER_CYCLE, 2: digits decoded and accumulated per RUN cycle; must divide ND (legal values 1, 2, 4, 8).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- mcand_i  in  REG_WIDTH  multiplicand M.
- mcand_signed_i  in  1  1: M is sign-extended; 0: M is zero-extended.
- zero_index_i  in  REG_WIDTH/2  per-digit "digit is 0".
- invert_index_i  in  REG_WIDTH/2  per-digit "digit is negative".
- double_index_i  in  REG_WIDTH/2  per-digit "|digit| = 2".
- flush_i  in  1  synchronous abort.
- valid_o  out  1  product valid.
- ready_i  in  1  consumer accepts the product.
- product_o  out  2*REG_WIDTH  result.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, ready_o = 1, valid_o = 0, product_o = 0, digit counter = 0.
- States:
  - IDLE: ready_o = 1. If valid_i is high at a clock edge:
    - latch mcand_i, mcand_signed_i and all three index vectors;
    - clear the accumulator and set counter = 0;
    - go to RUN.
  - RUN: ready_o = 0. Each edge adds the partial products of digits cnt .. cnt+DIGITS_PER_CYCLE-1 and advances cnt by DIGITS_PER_CYCLE.
    - The edge that processes digit ND-1 writes the final sum to product_o, sets valid_o = 1 and goes to DONE.
  - DONE: ready_o = 0; valid_o and product_o are held stable.
    - valid_o && ready_i at an edge: valid_o goes to 0, go to IDLE. product_o keeps its last value.
- Latency:
  - Request accepted at edge t gives valid_o = 1 after edge t + ND/DIGITS_PER_CYCLE (t+16 with defaults).
  - Minimum spacing between accepts is ND/DIGITS_PER_CYCLE + 2 edges. There is no overlap and no request/response bypass.
- Digit decode, with Me = M extended to 2·REG_WIDTH bits per mcand_signed_i:
  - zero = 1: partial product = 0. Zero takes priority over invert and double, so illegal combinations are defined.
  - Otherwise: base = double ? Me<<1 : Me; pp = invert ? -base (two's complement) : base.
  - Contribution of digit i = pp << (2·i).
- Arithmetic:
  - All adds are modulo 2^(2·REG_WIDTH); overflow out of the top bit is discarded.
  - The multiplier is the signed value the digits represent.
  - Result = signed(multiplier) × Me mod 2^(2·REG_WIDTH).
- flush_i:
  - Highest priority in every state. At the edge: state = IDLE, valid_o = 0, counter = 0. product_o is unchanged.
  - valid_i in the same cycle as flush_i is not accepted.
- Input changes outside the accept edge have no effect; operands are used only from the latched copies.
- Reset asserted mid-RUN or in DONE: outputs immediately return to their reset values and the result is lost.

Test Plan:
- M = 3 (unsigned), digits for multiplier 5: digit0 and digit1 = +1, all other digits zero=1 -> valid_o after 16 edges, product_o = 15.
- M = 7, multiplier −1: digit0 invert=1, double=0, zero=0; all other digits zero=1 -> product_o = 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9.
- Unsigned vs signed multiplicand, M = 0xFFFF_FFFF_FFFF_FFFF, multiplier 2 (digit0 = −2: invert=1, double=1; digit1 = +1):
  - mcand_signed_i = 0 -> product_o = 0x0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE;
  - mcand_signed_i = 1 -> product_o = −2 (0xFFFF…FFFE).
- Back-pressure: hold ready_i = 0 for 5 cycles after valid_o -> valid_o and product_o stay stable and ready_o = 0; ready_i = 1 -> IDLE on the next edge, then a new request is accepted.
- flush_i pulsed at RUN edge 7 -> IDLE, valid_o never asserts. The next request (M = 3, multiplier 5) completes with 15.
- Reset during RUN and illegal codes:
  - rst_n_i = 0 during RUN -> ready_o = 1, valid_o = 0, product_o = 0 with no clock edge.
  - All digits zero=1 with invert=1 and double=1 -> product_o = 0.
